// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if: request, shared-adder and response signals of adder_arbiter (rsp_overflow only with ADDER_ARBITER_OVF_EN)
interface adder_arbiter_if #(
   parameter int REQ_NUM = 4,
   parameter int DATA_WIDTH = 4
);
   localparam int ID_WIDTH = $clog2(REQ_NUM);
   logic [REQ_NUM-1:0] req_valid;
   logic [REQ_NUM-1:0] req_ready;
   logic [REQ_NUM*DATA_WIDTH-1:0] req_a;
   logic [REQ_NUM*DATA_WIDTH-1:0] req_b;
   logic [DATA_WIDTH-1:0] adder_a;
   logic [DATA_WIDTH-1:0] adder_b;
   logic [DATA_WIDTH-1:0] adder_sum;
   logic rsp_valid;
   logic rsp_ready;
   logic [ID_WIDTH-1:0] rsp_id;
   logic [DATA_WIDTH-1:0] rsp_sum;
`ifdef ADDER_ARBITER_OVF_EN
   logic rsp_overflow;
   modport master (
      output req_valid, req_a, req_b, adder_sum, rsp_ready,
      input req_ready, adder_a, adder_b, rsp_valid, rsp_id, rsp_sum, rsp_overflow
   );
   modport slave (
      input req_valid, req_a, req_b, adder_sum, rsp_ready,
      output req_ready, adder_a, adder_b, rsp_valid, rsp_id, rsp_sum, rsp_overflow
   );
`else
   modport master (
      output req_valid, req_a, req_b, adder_sum, rsp_ready,
      input req_ready, adder_a, adder_b, rsp_valid, rsp_id, rsp_sum
   );
   modport slave (
      input req_valid, req_a, req_b, adder_sum, rsp_ready,
      output req_ready, adder_a, adder_b, rsp_valid, rsp_id, rsp_sum
   );
`endif
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one combinational adder among REQ_NUM requesters; ADDER_ARBITER_OVF_EN adds rsp_overflow
module adder_arbiter #(
   parameter int REQ_NUM = 4,
   parameter int DATA_WIDTH = 4
) (
   input logic clk,
   input logic rst,
   adder_arbiter_if.slave bus
);
   localparam int ID_WIDTH = $clog2(REQ_NUM);
   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
   state_t state, state_nxt;
   logic [ID_WIDTH-1:0] rr_ptr;
   logic [ID_WIDTH-1:0] gnt_id;
   logic gnt_found;
   logic hs;
   logic [DATA_WIDTH-1:0] a_sel;
   logic [DATA_WIDTH-1:0] b_sel;
   int idx;

   // first valid requester searching upward from rr_ptr with wrap
   always_comb begin
      gnt_found = 1'b0;
      gnt_id = '0;
      idx = 0;
      for (int k = 0; k < REQ_NUM; k++) begin
         idx = int'(rr_ptr) + k;
         idx = idx >= REQ_NUM ? idx - REQ_NUM : idx;
         if (!gnt_found && bus.req_valid[ID_WIDTH'(idx)]) begin
            gnt_found = 1'b1;
            gnt_id = ID_WIDTH'(idx);
         end
      end
   end

   // operand mux for the winning requester
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int k = 0; k < REQ_NUM; k++) begin
         if (gnt_id == ID_WIDTH'(k)) begin
            a_sel = bus.req_a[k*DATA_WIDTH +: DATA_WIDTH];
            b_sel = bus.req_b[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign hs = state == IDLE && !rst && gnt_found;
   assign bus.req_ready = hs ? REQ_NUM'(1) << gnt_id : '0;
   assign bus.rsp_valid = state == RESP;

   // state register
   always_ff @(posedge clk) begin
      state <= rst ? IDLE : state_nxt;
   end

   // next state: IDLE -> CALC on grant, CALC -> RESP, RESP -> IDLE on rsp_ready
   always_comb begin
      state_nxt = state;
      state_nxt = state == IDLE ? (hs ? CALC : IDLE) :
                  state == CALC ? RESP :
                  bus.rsp_ready ? IDLE : RESP;
   end

   // grant capture into operand registers, result capture in CALC
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
         bus.adder_a <= '0;
         bus.adder_b <= '0;
         bus.rsp_id <= '0;
         bus.rsp_sum <= '0;
`ifdef ADDER_ARBITER_OVF_EN
         bus.rsp_overflow <= 1'b0;
`endif
      end else begin
         if (hs) begin
            bus.adder_a <= a_sel;
            bus.adder_b <= b_sel;
            bus.rsp_id <= gnt_id;
            rr_ptr <= gnt_id == ID_WIDTH'(REQ_NUM - 1) ? '0 : gnt_id + ID_WIDTH'(1);
         end
         if (state == CALC) begin
            bus.rsp_sum <= bus.adder_sum;
`ifdef ADDER_ARBITER_OVF_EN
            bus.rsp_overflow <= bus.adder_sum < bus.adder_a;
`endif
         end
      end
   end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed vectors and multi-cycle sequences for adder_arbiter
module tb_adder_arbiter;
   localparam int RN = 4;
   localparam int DW = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;

   adder_arbiter_if #(.REQ_NUM(RN), .DATA_WIDTH(DW)) bus ();
   adder_arbiter #(.REQ_NUM(RN), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

   assign bus.adder_sum = bus.adder_a + bus.adder_b;
   always #5 clk = ~clk;

   typedef struct {
      int id;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] sum;
      logic ovf;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      vecs[0] = '{0, 4'd5, 4'd6, 4'd11, 1'b0};
      vecs[1] = '{2, 4'd9, 4'd9, 4'd2, 1'b1};
      vecs[2] = '{2, 4'd7, 4'd8, 4'd15, 1'b0};
      vecs[3] = '{3, 4'd15, 4'd1, 4'd0, 1'b1};
      vecs[4] = '{1, 4'd0, 4'd0, 4'd0, 1'b0};
      vecs[5] = '{3, 4'd15, 4'd15, 4'd14, 1'b1};
      bus.req_valid = '1;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("ready_in_rst", 32'(bus.req_ready), 0);
      bus.req_valid = '0;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_adder_a", 32'(bus.adder_a), 0);
      chk("rst_adder_b", 32'(bus.adder_b), 0);
      chk("rst_rsp_id", 32'(bus.rsp_id), 0);
      chk("rst_rsp_sum", 32'(bus.rsp_sum), 0);
`ifdef ADDER_ARBITER_OVF_EN
      chk("rst_ovf", 32'(bus.rsp_overflow), 0);
`endif

      // single-requester vectors
      for (int i = 0; i < 6; i++) begin
         bus.req_valid = 4'(1 << vecs[i].id);
         bus.req_a = 16'(vecs[i].a) << (vecs[i].id * 4);
         bus.req_b = 16'(vecs[i].b) << (vecs[i].id * 4);
         #1 chk("vec_ready", 32'(bus.req_ready), 32'(1 << vecs[i].id));
         @(negedge clk);
         bus.req_valid = '0;
         chk("vec_early_valid", 32'(bus.rsp_valid), 0);
         @(negedge clk);
         chk("vec_rsp_valid", 32'(bus.rsp_valid), 1);
         chk("vec_rsp_id", 32'(bus.rsp_id), 32'(vecs[i].id));
         chk("vec_rsp_sum", 32'(bus.rsp_sum), 32'(vecs[i].sum));
`ifdef ADDER_ARBITER_OVF_EN
         chk("vec_ovf", 32'(bus.rsp_overflow), 32'(vecs[i].ovf));
`endif
         bus.rsp_ready = 1'b1;
         @(negedge clk);
         bus.rsp_ready = 1'b0;
      end

      // all four valid: round-robin order, one response every 3 cycles
      bus.req_valid = 4'b1111;
      bus.req_a = 16'h3210;
      bus.req_b = 16'h1111;
      bus.rsp_ready = 1'b1;
      for (int g = 0; g < 8; g++) begin
         #1 chk("rr_grant", 32'(bus.req_ready), 32'(1 << (g % 4)));
         @(negedge clk);
         chk("rr_calc_ready", 32'(bus.req_ready), 0);
         chk("rr_calc_valid", 32'(bus.rsp_valid), 0);
         @(negedge clk);
         chk("rr_rsp_valid", 32'(bus.rsp_valid), 1);
         chk("rr_rsp_id", 32'(bus.rsp_id), 32'(g % 4));
         chk("rr_rsp_sum", 32'(bus.rsp_sum), 32'(g % 4 + 1));
         @(negedge clk);
      end
      bus.req_valid = '0;
      bus.rsp_ready = 1'b0;

      // backpressure: response held while req1 waits
      bus.req_valid = 4'b0001;
      bus.req_a = 16'h0001;
      bus.req_b = 16'h0001;
      #1 chk("bp_grant0", 32'(bus.req_ready), 1);
      @(negedge clk);
      bus.req_valid = 4'b0010;
      bus.req_a = 16'h0020;
      bus.req_b = 16'h0030;
      chk("bp_calc_ready", 32'(bus.req_ready), 0);
      @(negedge clk);
      repeat (5) begin
         chk("bp_hold_valid", 32'(bus.rsp_valid), 1);
         chk("bp_hold_sum", 32'(bus.rsp_sum), 2);
         chk("bp_hold_ready", 32'(bus.req_ready), 0);
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk("bp_grant1", 32'(bus.req_ready), 2);
      @(negedge clk);
      bus.req_valid = '0;
      @(negedge clk);
      chk("bp_rsp_id", 32'(bus.rsp_id), 1);
      chk("bp_rsp_sum", 32'(bus.rsp_sum), 5);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;

      // reset during CALC aborts and returns rr_ptr to 0
      bus.req_valid = 4'b0010;
      bus.req_a = 16'h0010;
      bus.req_b = 16'h0010;
      #1 chk("ab_grant1", 32'(bus.req_ready), 2);
      @(negedge clk);
      rst = 1'b1;
      bus.req_valid = 4'b1111;
      #1 chk("ab_ready_in_rst", 32'(bus.req_ready), 0);
      @(negedge clk);
      rst = 1'b0;
      bus.req_valid = '0;
      chk("ab_adder_a", 32'(bus.adder_a), 0);
      chk("ab_adder_b", 32'(bus.adder_b), 0);
      chk("ab_rsp_id", 32'(bus.rsp_id), 0);
      chk("ab_rsp_sum", 32'(bus.rsp_sum), 0);
      repeat (3) begin
         chk("ab_no_rsp", 32'(bus.rsp_valid), 0);
         @(negedge clk);
      end
      bus.req_valid = 4'b1010;
      bus.req_a = 16'h0060;
      bus.req_b = 16'h0010;
      #1 chk("ab_ptr_zero", 32'(bus.req_ready), 2);
      @(negedge clk);
      bus.req_valid = '0;
      @(negedge clk);
      chk("ab_rsp_id2", 32'(bus.rsp_id), 1);
      chk("ab_rsp_sum2", 32'(bus.rsp_sum), 7);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;

      // req1 pulses valid while req0 is in flight
      bus.req_valid = 4'b0001;
      bus.req_a = 16'h0004;
      bus.req_b = 16'h0004;
      #1 chk("wd_grant0", 32'(bus.req_ready), 1);
      @(negedge clk);
      bus.req_valid = 4'b0010;
      chk("wd_calc_ready", 32'(bus.req_ready), 0);
      @(negedge clk);
      bus.req_valid = '0;
      chk("wd_rsp_id", 32'(bus.rsp_id), 0);
      chk("wd_rsp_sum", 32'(bus.rsp_sum), 8);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      repeat (4) begin
         chk("wd_no_grant", 32'(bus.req_ready), 0);
         chk("wd_no_rsp", 32'(bus.rsp_valid), 0);
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
